dct_postifft_reod_1200out: RTL and testbench
============================================

DCT_POSTIFFT_REOD_1200OUT -- requirements
Module: dct_postIFFT_reod_1200out

Interface
REQ-001 SHALL have parameter wDataInOut, default 16, giving the width of each real and imaginary sample.
REQ-002 SHALL have parameter FFTPTS, default 2048, giving the frame length N (power of 2).
REQ-003 SHALL have parameter OUT_START, default 1448, the first output index.
REQ-004 SHALL have parameter OUT_END, default 600, the last output index.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have sink ports (all inputs except sink_ready):
- sink_valid, 1
- sink_ready (output reg), 1
- sink_error, 2 (ignored)
- sink_sop, 1
- sink_eop, 1
- sink_real, wDataInOut
- sink_imag, wDataInOut
REQ-008 SHALL have source ports (all outputs except source_ready):
- source_valid, 1
- source_ready (input), 1
- source_error, 2 (tied 2'b00)
- source_sop, 1
- source_eop, 1
- source_real, wDataInOut
- source_imag, wDataInOut

Function
REQ-009 SHALL accept one natural-order IFFT frame y0..y(N-1) and output the inverse of the pre-FFT reorder.
- The mapping is x[2k] = y[k] and x[2k+1] = y[N-1-k].
- Only the 1200-sample window x1448..x2047, x1..x600 is output, in that order.
REQ-010 SHALL write sample y_k to RAM address 2k when k < N/2, and to address 2(N-1-k)+1 otherwise.
- k is an 11-bit input counter advanced on each sink_valid & sink_ready.
REQ-011 SHALL use FSM states IDLE, WRITE, WAIT and READ.
- IDLE -> WRITE on an accepted beat with sink_sop (written as k=0).
- WRITE -> WAIT on an accepted beat with sink_eop when k = N-1.
- WAIT -> READ when source_ready = 1.
- READ -> IDLE after the read counter r reaches 1199.
REQ-012 SHALL drive sink_ready = 1 in IDLE and WRITE and 0 in WAIT and READ.
- The write takes effect on the accepted beat; ready falls the cycle after eop.
REQ-013 SHALL generate the read address from counter r = 0..1199 in READ.
- Address = OUT_START + r for r < 600.
- Address = r - 599 for r >= 600.
REQ-014 SHALL output each sample exactly two cycles after its address is issued (RAM read 1 cycle plus output register 1 cycle).
- The first source_valid occurs 2 cycles after entering READ.
REQ-015 SHALL assert source_valid for exactly 1200 consecutive cycles, with source_sop on the first beat and source_eop on the 1200th beat.
- source_ready is sampled only in WAIT; a READ burst is not stalled.
REQ-016 SHALL restart the frame when sink_sop arrives in WRITE: that beat is written as k=0.
REQ-017 SHALL discard a short frame (sink_eop accepted with k != N-1) and return to IDLE with no output.
REQ-018 SHALL discard a frame whose beat at k = N-1 lacks sink_eop: return to IDLE, no output.
REQ-019 SHALL ignore sink_valid outside IDLE and WRITE, performing no RAM write.

Reset
REQ-020 SHALL, while rst_n = 0, immediately force the following, including mid-frame and mid-burst:
- FSM to IDLE and counters k, r to 0;
- sink_ready, source_valid, source_sop, source_eop to 0;
- source_real and source_imag to 0.
RAM contents are not reset.
REQ-021 SHALL, after rst_n deasserts, raise sink_ready = 1 on the first clock edge and wait for a new sink_sop.

Structure
REQ-022 SHALL keep FFTPTS, OUT_START, OUT_END, the FSM state encoding and the 1200-sample frame count in the shared DCT package.
REQ-023 SHALL instantiate one sub-module, RAM_dct_postIFFT_reod: simple dual-port, depth 2048, width 2*wDataInOut, registered 1-cycle read, single clock.

Verification
REQ-024 SHALL check the ramp frame: y_k.real = k, y_k.imag = -k.
- Beat 1 = (724, -724) with sop; beat 2 = 1323; beat 600 = x2047 = y1024 = 1024.
- Beat 601 = x1 = y2047 = 2047; beat 1200 = x600 = y300 = 300 with eop.
REQ-025 SHALL check backpressure: source_ready held low for 50 cycles after the frame.
- Expect no source_valid while low; after release, the burst starts 2 cycles after the READ entry, then 1200 contiguous beats.
REQ-026 SHALL check a short frame: sop at k=0, eop at k=999.
- Expect no output, sink_ready stays 1, and a following full ramp frame reproduces REQ-024 exactly.
REQ-027 SHALL check sink_sop re-issued at k=500 in WRITE, followed by 2048 beats.
- Expect output computed from the restarted frame only.
REQ-028 SHALL check rst_n pulsed low at beat 300 of a READ burst.
- Expect all outputs 0 asynchronously, sink_ready = 1 after release, and correct output for the next frame.
REQ-029 SHALL check sink_valid gapped at 50% duty within a frame.
- Expect output identical to REQ-024 and sink_ready low from the cycle after eop until the READ burst completes.

Source files
------------

// File: rtl/dct_postifft_reod_1200out_pkg.sv
// Shared DCT post-IFFT reorder constants and FSM encoding.
// Frame length, output window and 1200-sample output count.
package dct_postifft_reod_1200out_pkg;

  localparam int FFTPTS    = 2048;
  localparam int OUT_START = 1448;
  localparam int OUT_END   = 600;
  localparam int FRAME_CNT = FFTPTS - OUT_START + OUT_END;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2,
    S_READ  = 2'd3
  } state_t;

endpackage

// File: rtl/dct_postifft_reod_1200out_ram.sv
// Simple dual-port frame RAM, one write port, one registered read port.
// Ports: i_we/i_waddr/i_wdata write; i_re/i_raddr read; o_rdata 1-cycle.
module RAM_dct_postIFFT_reod
  import dct_postifft_reod_1200out_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = dct_postifft_reod_1200out_pkg::FFTPTS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/dct_postifft_reod_1200out.sv
// Undo the pre-FFT even/odd reorder and emit the 1200-sample window.
// Ports: sink_* Avalon-ST frame in, source_* 1200-beat burst out.
module dct_postifft_reod_1200out
  import dct_postifft_reod_1200out_pkg::*;
#(
  parameter int wDataInOut = 16,
  parameter int FFTPTS    = dct_postifft_reod_1200out_pkg::FFTPTS,
  parameter int OUT_START = dct_postifft_reod_1200out_pkg::OUT_START,
  parameter int OUT_END   = dct_postifft_reod_1200out_pkg::OUT_END
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic [1:0]            sink_error,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic [wDataInOut-1:0] sink_real,
  input  logic [wDataInOut-1:0] sink_imag,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic [1:0]            source_error,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic [wDataInOut-1:0] source_real,
  output logic [wDataInOut-1:0] source_imag
);

  localparam int W    = wDataInOut;
  localparam int AW   = $clog2(FFTPTS);
  localparam int HEAD = FFTPTS - OUT_START;
  localparam int NOUT = HEAD + OUT_END;

  localparam logic [AW-1:0] C_LAST  = AW'(FFTPTS - 1);
  localparam logic [AW-1:0] C_RLAST = AW'(NOUT - 1);
  localparam logic [AW-1:0] C_HEAD  = AW'(HEAD);
  localparam logic [AW-1:0] C_START = AW'(OUT_START);
  localparam logic [AW-1:0] C_WRAP  = AW'(HEAD - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_r;
  logic          w_acc;
  logic          w_we;
  logic          w_re;
  logic [AW-1:0] w_kw;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;
  logic [2*W-1:0] w_q;
  logic          r_v1;
  logic          r_sop1;
  logic          r_eop1;
  logic          w_unused_err;

  assign w_unused_err = ^sink_error;
  assign source_error = 2'b00;
  assign w_acc        = sink_valid & sink_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && sink_sop) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_acc) begin
          if (sink_sop)
            w_next = S_WRITE;
          else if (sink_eop)
            w_next = (r_k == C_LAST) ? S_WAIT : S_IDLE;
          else if (r_k == C_LAST)
            w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (source_ready) w_next = S_READ;
      end
      S_READ: begin
        if (r_r == C_RLAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode: RAM write/read controls
  always_comb begin
    w_we = 1'b0;
    w_re = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE):  w_we = w_acc & sink_sop;
      (r_state == S_WRITE): w_we = w_acc;
      (r_state == S_READ):  w_re = 1'b1;
      default: ;
    endcase
  end

  // sop always lands at k=0, even as a mid-frame restart.
  assign w_kw = sink_sop ? '0 : r_k;

  // Upper half is mirrored: N-1-k equals ~k for power-of-2 N.
  assign w_waddr = w_kw[AW-1] ? {~w_kw[AW-2:0], 1'b1}
                              : { w_kw[AW-2:0], 1'b0};

  assign w_raddr = (r_r < C_HEAD) ? C_START + r_r
                                  : r_r - C_WRAP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k <= '0;
      r_r <= '0;
      sink_ready <= 1'b0;
    end else begin
      if (w_next != S_WRITE) r_k <= '0;
      else if (w_we)         r_k <= w_kw + AW'(1);
      if (w_re && w_next == S_READ) r_r <= r_r + AW'(1);
      else                          r_r <= '0;
      sink_ready <= (w_next == S_IDLE) ||
                    (w_next == S_WRITE);
    end
  end

  // Two-stage output pipe: RAM read, then output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_sop1 <= 1'b0;
      r_eop1 <= 1'b0;
      source_valid <= 1'b0;
      source_sop <= 1'b0;
      source_eop <= 1'b0;
      source_real <= '0;
      source_imag <= '0;
    end else begin
      r_v1 <= w_re;
      r_sop1 <= w_re && (r_r == '0);
      r_eop1 <= w_re && (r_r == C_RLAST);
      source_valid <= r_v1;
      source_sop <= r_sop1;
      source_eop <= r_eop1;
      if (r_v1) begin
        source_real <= w_q[2*W-1:W];
        source_imag <= w_q[W-1:0];
      end
    end
  end

  RAM_dct_postIFFT_reod #(
    .DW    (2*W),
    .DEPTH (FFTPTS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata ({sink_real, sink_imag}),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_q)
  );

endmodule

// File: tb/tb_dct_postifft_reod_1200out.sv
// Directed bench for the post-IFFT reorder with output scoreboard.
// Ports: drives sink_*/source_ready, checks source_* against model.
module tb_dct_postifft_reod_1200out;

  logic        clk;
  logic        rst_n;
  logic        sink_valid;
  logic        sink_ready;
  logic [1:0]  sink_error;
  logic        sink_sop;
  logic        sink_eop;
  logic [15:0] sink_real;
  logic [15:0] sink_imag;
  logic        source_valid;
  logic        source_ready;
  logic [1:0]  source_error;
  logic        source_sop;
  logic        source_eop;
  logic [15:0] source_real;
  logic [15:0] source_imag;

  int n_assert = 0;
  int n_fail   = 0;
  int run      = 0;
  int last_burst = 0;
  int ready_bad  = 0;

  logic [31:0] ym [2048];
  logic [33:0] q [$];

  dct_postifft_reod_1200out dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_error   (sink_error),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_error (source_error),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every output beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else if (source_valid) begin
      if (run < 1198 && sink_ready) ready_bad++;
      chk("qnonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0)
        chk($sformatf("beat%0d", run + 1),
            64'({source_real, source_imag,
                 source_sop, source_eop}),
            64'(q.pop_front()));
      run++;
    end else begin
      if (run != 0) last_burst = run;
      run = 0;
    end
  end

  task automatic send_frame(input int n, input int off,
                            input bit with_eop,
                            input bit gap);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sink_valid = 1'b1;
      sink_sop   = (k == 0);
      sink_eop   = with_eop && (k == n - 1);
      sink_real  = 16'(k + off);
      sink_imag  = 16'(-(k + off));
      ym[k]      = {sink_real, sink_imag};
      if (gap) begin
        @(negedge clk);
        sink_valid = 1'b0;
      end
    end
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  // Model of the inverse reorder over the output window.
  task automatic push_exp();
    for (int j = 0; j < 1200; j++) begin
      int n;
      int y;
      n = (j < 600) ? 1448 + j : j - 599;
      y = (n % 2 == 0) ? n / 2 : 2047 - (n - 1) / 2;
      q.push_back({ym[y], 1'(j == 0), 1'(j == 1199)});
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_drained"}, 64'(q.size()), 64'd0);
    chk({tag, "_burst"}, 64'(last_burst), 64'd1200);
    chk({tag, "_rdylow"}, 64'(ready_bad), 64'd0);
  endtask

  initial begin
    int cnt;
    int hits;
    rst_n = 1'b0;
    sink_valid = 1'b0;
    sink_error = 2'b11;
    sink_sop = 1'b0;
    sink_eop = 1'b0;
    sink_real = '0;
    sink_imag = '0;
    source_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(sink_ready), 64'd0);
    chk("rst_valid", 64'(source_valid), 64'd0);
    chk("rst_sop", 64'(source_sop), 64'd0);
    chk("rst_eop", 64'(source_eop), 64'd0);
    chk("rst_data", 64'({source_real, source_imag}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(sink_ready), 64'd1);
    chk("src_error", 64'(source_error), 64'd0);

    // Ramp frame
    send_frame(2048, 0, 1'b1, 1'b0);
    chk("eop_ready", 64'(sink_ready), 64'd0);
    push_exp();
    drain("ramp");

    // Backpressure
    source_ready = 1'b0;
    send_frame(2048, 0, 1'b1, 1'b0);
    push_exp();
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (source_valid) hits++;
    end
    chk("bp_novalid", 64'(hits), 64'd0);
    source_ready = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!source_valid && cnt < 20);
    chk("bp_latency", 64'(cnt), 64'd3);
    drain("bp");

    // Short frame: eop at k=999
    send_frame(1000, 0, 1'b1, 1'b0);
    chk("short_ready", 64'(sink_ready), 64'd1);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (source_valid) hits++;
    end
    chk("short_noout", 64'(hits), 64'd0);
    send_frame(2048, 0, 1'b1, 1'b0);
    push_exp();
    drain("after_short");

    // sop re-issued at k=500
    send_frame(500, 3000, 1'b0, 1'b0);
    chk("restart_ready", 64'(sink_ready), 64'd1);
    send_frame(2048, 11, 1'b1, 1'b0);
    push_exp();
    drain("restart");

    // Reset at beat 300 of a burst
    send_frame(2048, 40, 1'b1, 1'b0);
    push_exp();
    cnt = 0;
    while (run < 300 && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    chk("reached_300", 64'(run), 64'd300);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", 64'(source_valid), 64'd0);
    chk("mid_sopeop", 64'({source_sop, source_eop}), 64'd0);
    chk("mid_data", 64'({source_real, source_imag}), 64'd0);
    chk("mid_ready", 64'(sink_ready), 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(sink_ready), 64'd1);
    chk("rel_valid", 64'(source_valid), 64'd0);
    send_frame(2048, 77, 1'b1, 1'b0);
    push_exp();
    drain("after_rst");

    // 50% duty input
    send_frame(2048, 0, 1'b1, 1'b1);
    chk("gap_ready", 64'(sink_ready), 64'd0);
    push_exp();
    drain("gapped");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
